// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared widths, pair type and saturation helper for the L=2 FIR output path
package filter_pkg;

    localparam int ACC_W    = 64;
    localparam int SAMPLE_W = 32;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef struct packed {
        logic [SAMPLE_W-1:0] even;
        logic [SAMPLE_W-1:0] odd;
    } sample_pair_t;

    typedef struct packed {
        logic                clip;
        logic [SAMPLE_W-1:0] data;
    } sat_result_t;

    function automatic sat_result_t sat_to_sample(input logic signed [ACC_W-1:0] value,
                                                  input logic                    sat_en);
        sat_result_t res;
        res.clip = 1'b0;
        res.data = value[SAMPLE_W-1:0];
        if (sat_en) begin
            if (value > SAT_MAX) begin
                res.clip = 1'b1;
                res.data = SAT_MAX[SAMPLE_W-1:0];
            end else if (value < SAT_MIN) begin
                res.clip = 1'b1;
                res.data = SAT_MIN[SAMPLE_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_pair_fifo.sv
// rtl/fir_pair_fifo.sv - DEPTH-entry FIFO of converted even/odd sample pairs
module fir_pair_fifo
    import filter_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  sample_pair_t     i_push_data,
    input  logic             i_pop,
    output sample_pair_t     o_head_data,
    output logic [LVL_W-1:0] o_level
);

    sample_pair_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_comb begin
        o_head_data = r_mem[r_rd_ptr];
        o_level     = r_level;
    end

endmodule

// File: rtl/fir_l2_output_serializer.sv
// rtl/fir_l2_output_serializer.sv - saturates L=2 FIR output pairs, buffers them and emits one sample per transfer
module fir_l2_output_serializer #(
    parameter int  ACC_W    = 64,
    parameter int  SAMPLE_W = 32,
    parameter int  DEPTH    = 4,
    parameter bit  SAT_EN   = 1'b1,
    parameter int  DROP_W   = 16,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [ACC_W-1:0]    in_even,
    input  logic signed [ACC_W-1:0]    in_odd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SAMPLE_W-1:0]        out_data,
    output logic                       out_phase,
    output logic [LVL_W-1:0]           level,
    output logic                       sat_flag,
    output logic [DROP_W-1:0]          drop_count
);
    import filter_pkg::*;

    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic               r_alive;
    logic               r_phase;
    logic               r_sat;
    logic [DROP_W-1:0]  r_drop;

    logic               w_phase_next;
    logic               w_sat_next;
    logic [DROP_W-1:0]  w_drop_next;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_xfer;
    sat_result_t        w_even_sat;
    sat_result_t        w_odd_sat;
    sample_pair_t       w_push_pair;
    sample_pair_t       w_head_pair;
    logic [LVL_W-1:0]   w_level;

    fir_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_pair),
        .i_pop       (w_pop),
        .o_head_data (w_head_pair),
        .o_level     (w_level)
    );

    // r_alive holds in_ready low for the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alive <= 1'b0;
            r_phase <= 1'b0;
            r_sat   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_alive <= 1'b1;
            r_phase <= w_phase_next;
            r_sat   <= w_sat_next;
            r_drop  <= w_drop_next;
        end
    end

    always_comb begin
        w_even_sat       = sat_to_sample(in_even, SAT_EN);
        w_odd_sat        = sat_to_sample(in_odd, SAT_EN);
        w_push_pair.even = w_even_sat.data;
        w_push_pair.odd  = w_odd_sat.data;

        w_in_ready  = r_alive && (w_level < FULL_LVL);
        w_out_valid = (w_level != '0);
        w_push      = in_valid && w_in_ready;
        w_xfer      = w_out_valid && out_ready;
        w_pop       = w_xfer && r_phase;

        w_phase_next = r_phase ^ w_xfer;
        w_sat_next   = r_sat || (w_push && (w_even_sat.clip || w_odd_sat.clip));
        w_drop_next  = r_drop;
        if (in_valid && !w_in_ready && (r_drop != DROP_MAX)) begin
            w_drop_next = r_drop + 1'b1;
        end
    end

    always_comb begin
        in_ready   = w_in_ready;
        out_valid  = w_out_valid;
        out_phase  = r_phase;
        out_data   = '0;
        if (w_out_valid) begin
            out_data = r_phase ? w_head_pair.odd : w_head_pair.even;
        end
        level      = w_level;
        sat_flag   = r_sat;
        drop_count = r_drop;
    end

endmodule

// File: tb/tb_fir_l2_output_serializer.sv
// tb/tb_fir_l2_output_serializer.sv - self-checking bench for fir_l2_output_serializer
module tb_fir_l2_output_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid;
    logic               out_ready;
    logic signed [63:0] in_even;
    logic signed [63:0] in_odd;

    logic        in_ready_s, out_valid_s, out_phase_s, sat_flag_s;
    logic [31:0] out_data_s;
    logic [2:0]  level_s;
    logic [15:0] drop_s;

    logic        in_ready_r, out_valid_r, out_phase_r, sat_flag_r;
    logic [31:0] out_data_r;
    logic [2:0]  level_r;
    logic [15:0] drop_r;

    fir_l2_output_serializer #(.SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_even(in_even), .in_odd(in_odd), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_phase(out_phase_s), .level(level_s),
        .sat_flag(sat_flag_s), .drop_count(drop_s)
    );

    fir_l2_output_serializer #(.SAT_EN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_even(in_even), .in_odd(in_odd), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_phase(out_phase_r), .level(level_r),
        .sat_flag(sat_flag_r), .drop_count(drop_r)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_even = '0; in_odd = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic push_pair(input logic signed [63:0] e, input logic signed [63:0] o);
        in_valid = 1'b1; in_even = e; in_odd = o;
        next_cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] ref_sat(input logic signed [63:0] v);
        if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic bit ref_clip(input logic signed [63:0] v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    function automatic logic signed [63:0] rnd64();
        logic signed [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = 64'($signed($urandom));
            1:       v = {$urandom, $urandom};
            2:       v = 64'sd2147483646 + 64'($urandom_range(0, 3));
            default: v = -64'sd2147483649 + 64'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    typedef struct {
        logic [63:0] even;
        logic [63:0] odd;
        logic [31:0] e_sat;
        logic [31:0] o_sat;
        logic [31:0] e_raw;
        logic [31:0] o_raw;
        logic        clip;
    } vec_t;

    vec_t vecs[5];

    // Reference model: expected serial sample stream, oldest first.
    logic [31:0] q_s[$];
    logic [31:0] q_r[$];
    int          m_drop;
    bit          m_sat;
    bit          hold;
    logic [31:0] hold_data;
    logic        hold_phase;

    task automatic rand_cycle();
        int  exp_level;
        bit  exp_valid;
        bit  exp_ready;
        @(negedge clk);
        exp_level = (q_s.size() + 1) / 2;
        exp_valid = (q_s.size() != 0);
        exp_ready = (exp_level < 4);
        chk("rnd_level", 64'(level_s), 64'(exp_level));
        chk("rnd_out_valid", 64'(out_valid_s), 64'(exp_valid));
        chk("rnd_in_ready", 64'(in_ready_s), 64'(exp_ready));
        chk("rnd_drop", 64'(drop_s), 64'(m_drop));
        chk("rnd_sat", 64'(sat_flag_s), 64'(m_sat));
        if (exp_valid) begin
            chk("rnd_data", 64'(out_data_s), 64'(q_s[0]));
            chk("rnd_phase", 64'(out_phase_s), 64'(q_s.size() % 2));
            chk("rnd_raw_data", 64'(out_data_r), 64'(q_r[0]));
        end
        if (hold) begin
            chk("hold_data", 64'(out_data_s), 64'(hold_data));
            chk("hold_phase", 64'(out_phase_s), 64'(hold_phase));
        end
        hold       = exp_valid && !out_ready;
        hold_data  = exp_valid ? q_s[0] : 32'h0;
        hold_phase = 1'(q_s.size() % 2);
        if (exp_valid && out_ready) begin
            void'(q_s.pop_front());
            void'(q_r.pop_front());
        end
        if (in_valid) begin
            if (exp_ready) begin
                q_s.push_back(ref_sat(in_even));
                q_s.push_back(ref_sat(in_odd));
                q_r.push_back(in_even[31:0]);
                q_r.push_back(in_odd[31:0]);
                m_sat = m_sat || ref_clip(in_even) || ref_clip(in_odd);
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        next_cycle();
    endtask

    initial begin
        logic [31:0] ovf_exp[8];
        int          offered;
        int          cyc;

        vecs[0] = '{64'sd5, -64'sd3, 32'd5, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFD, 1'b0};
        vecs[1] = '{64'h0000_0001_0000_0000, 64'hFFFF_FF00_0000_0000,
                    32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 1'b1};
        vecs[2] = '{64'h0000_0000_7FFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                    32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[3] = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_7FFF_FFFF,
                    32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0005, 64'h7FFF_FFFF_FFFF_FFFF,
                    32'h8000_0000, 32'h7FFF_FFFF, 32'h5, 32'hFFFF_FFFF, 1'b1};

        // Reset state, then in_ready rises one cycle after release.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_even = '0; in_odd = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_s), 64'd0);
        chk("rst_out_valid", 64'(out_valid_s), 64'd0);
        chk("rst_out_phase", 64'(out_phase_s), 64'd0);
        chk("rst_out_data", 64'(out_data_s), 64'd0);
        chk("rst_level", 64'(level_s), 64'd0);
        chk("rst_sat", 64'(sat_flag_s), 64'd0);
        chk("rst_drop", 64'(drop_s), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready_low", 64'(in_ready_s), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("rel_in_ready_high", 64'(in_ready_s), 64'd1);

        // Conversion vectors on an empty FIFO with the sink always ready.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            out_ready = 1'b1;
            push_pair(vecs[i].even, vecs[i].odd);
            @(negedge clk);
            chk($sformatf("v%0d_even_valid", i), 64'(out_valid_s), 64'd1);
            chk($sformatf("v%0d_even_sat", i), 64'(out_data_s), 64'(vecs[i].e_sat));
            chk($sformatf("v%0d_even_phase", i), 64'(out_phase_s), 64'd0);
            chk($sformatf("v%0d_even_raw", i), 64'(out_data_r), 64'(vecs[i].e_raw));
            next_cycle();
            @(negedge clk);
            chk($sformatf("v%0d_odd_sat", i), 64'(out_data_s), 64'(vecs[i].o_sat));
            chk($sformatf("v%0d_odd_phase", i), 64'(out_phase_s), 64'd1);
            chk($sformatf("v%0d_odd_raw", i), 64'(out_data_r), 64'(vecs[i].o_raw));
            chk($sformatf("v%0d_sat_flag", i), 64'(sat_flag_s), 64'(vecs[i].clip));
            chk($sformatf("v%0d_raw_sat_flag", i), 64'(sat_flag_r), 64'd0);
            next_cycle();
            @(negedge clk);
            chk($sformatf("v%0d_empty_valid", i), 64'(out_valid_s), 64'd0);
            chk($sformatf("v%0d_empty_level", i), 64'(level_s), 64'd0);
        end

        // Overflow: five pairs into a four-deep FIFO with the sink stalled.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_even = 64'(i); in_odd = 64'(100 + i);
            @(negedge clk);
            chk($sformatf("ovf_in_ready_%0d", i), 64'(in_ready_s), 64'(i <= 4));
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_level", 64'(level_s), 64'd4);
        chk("ovf_drop", 64'(drop_s), 64'd1);
        chk("ovf_in_ready", 64'(in_ready_s), 64'd0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            ovf_exp[2*k]   = 32'(k + 1);
            ovf_exp[2*k+1] = 32'(101 + k);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("drain_data_%0d", k), 64'(out_data_s), 64'(ovf_exp[k]));
            chk($sformatf("drain_phase_%0d", k), 64'(out_phase_s), 64'(k % 2));
            chk($sformatf("drain_level_%0d", k), 64'(level_s), 64'(4 - k / 2));
            chk($sformatf("drain_in_ready_%0d", k), 64'(in_ready_s), 64'(k >= 2));
            next_cycle();
        end
        @(negedge clk);
        chk("drain_done_valid", 64'(out_valid_s), 64'd0);

        // Push and pop in the same cycle at level 1, phase 1.
        do_reset();
        push_pair(64'sd10, 64'sd20);
        out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b1; in_even = 64'sd30; in_odd = 64'sd40;
        @(negedge clk);
        chk("pp_phase_before", 64'(out_phase_s), 64'd1);
        chk("pp_data_before", 64'(out_data_s), 64'd20);
        chk("pp_level_before", 64'(level_s), 64'd1);
        next_cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("pp_level_after", 64'(level_s), 64'd1);
        chk("pp_data_after", 64'(out_data_s), 64'd30);
        chk("pp_phase_after", 64'(out_phase_s), 64'd0);

        // Reset mid-drain with level=3, sticky flag set and a drop recorded.
        do_reset();
        push_pair(64'h0000_0001_0000_0000, 64'sd1);
        push_pair(64'sd2, 64'sd3);
        push_pair(64'sd4, 64'sd5);
        push_pair(64'sd6, 64'sd7);
        push_pair(64'sd8, 64'sd9);
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_level", 64'(level_s), 64'd3);
        chk("mid_phase", 64'(out_phase_s), 64'd1);
        chk("mid_data", 64'(out_data_s), 64'd3);
        chk("mid_drop", 64'(drop_s), 64'd1);
        chk("mid_sat", 64'(sat_flag_s), 64'd1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid_s), 64'd0);
        chk("post_rst_level", 64'(level_s), 64'd0);
        chk("post_rst_drop", 64'(drop_s), 64'd0);
        chk("post_rst_sat", 64'(sat_flag_s), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready_s), 64'd0);
        chk("post_rst_phase", 64'(out_phase_s), 64'd0);
        chk("post_rst_data", 64'(out_data_s), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("post_rst_in_ready_rise", 64'(in_ready_s), 64'd1);
        chk("post_rst_valid_still", 64'(out_valid_s), 64'd0);

        // Randomized traffic against the queue model.
        do_reset();
        q_s.delete(); q_r.delete();
        m_drop = 0; m_sat = 1'b0; hold = 1'b0;
        offered = 0; cyc = 0;
        while (offered < 200 && cyc < 5000) begin
            in_valid  = ($urandom_range(0, 99) < 55);
            in_even   = rnd64();
            in_odd    = rnd64();
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid) offered++;
            rand_cycle();
            cyc++;
        end
        chk("rnd_offered", 64'(offered), 64'd200);
        in_valid = 1'b0;
        cyc = 0;
        while (q_s.size() != 0 && cyc < 40) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            rand_cycle();
            cyc++;
        end
        chk("rnd_drained", 64'(q_s.size()), 64'd0);
        @(negedge clk);
        chk("rnd_final_valid", 64'(out_valid_s), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
